// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : riscv_pkg
//  Description : Shared types and constants for the fetch stage and the
//                branch unit: fetch FSM state encoding, NOP encoding,
//                BrOp codes and a PC increment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

    // Fetch FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0 -- presented to decode before the first real fetch
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential instruction stride in bytes
    localparam logic [31:0] c_pc_step = 32'd4;

    // Branch operation codes shared with the branch unit
    localparam logic [2:0] c_brop_none = 3'd0;
    localparam logic [2:0] c_brop_beq  = 3'd1;
    localparam logic [2:0] c_brop_bne  = 3'd2;
    localparam logic [2:0] c_brop_blt  = 3'd3;
    localparam logic [2:0] c_brop_bge  = 3'd4;
    localparam logic [2:0] c_brop_bltu = 3'd5;
    localparam logic [2:0] c_brop_bgeu = 3'd6;
    localparam logic [2:0] c_brop_jump = 3'd7;

    // Sequential successor of a PC; wraps modulo 2^32
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + c_pc_step;
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_pc_unit_pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Combinational next-PC selection. Not taken -> PC+4;
//                taken -> ALU target with low bits cleared. When
//                FETCH_MISALIGN_TRAP_EN is defined, a taken target with
//                bit 1 set redirects to TRAP_VEC and raises o_misalign.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_next_sel
    import riscv_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_alu_res,
    input  logic        i_next_pc_src,
    output logic [31:0] o_next_pc,
    output logic        o_misalign
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic c_trap_en = 1'b1;
`else
    localparam logic c_trap_en = 1'b0;
`endif

    logic [31:0] w_seq_pc;
    logic [31:0] w_taken_pc;
    logic        w_target_misaligned;
    logic        w_unused_alu_lsb;

    // Bit 0 is always discarded (JALR semantics), so it never reaches the PC
    assign w_unused_alu_lsb = i_alu_res[0];

    assign w_seq_pc            = pc_plus4(i_pc);
    assign w_target_misaligned = c_trap_en & i_alu_res[1];

    // Taken-target formation: trap redirect, half-aligned keep, or word-align
    always_comb begin
        w_taken_pc = {i_alu_res[31:2], 2'b00};
        if (w_target_misaligned) begin
            w_taken_pc = TRAP_VEC;
        end else if (c_trap_en) begin
            w_taken_pc = {i_alu_res[31:1], 1'b0};
        end
    end

    // Final mux between sequential and taken paths
    always_comb begin
        o_next_pc  = w_seq_pc;
        o_misalign = 1'b0;
        if (i_next_pc_src) begin
            o_next_pc  = w_taken_pc;
            o_misalign = w_target_misaligned;
        end
    end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : Program counter and instruction fetch stage. Issues a
//                req/ready request to instruction memory, waits for the
//                valid response, holds the instruction for decode and
//                advances the PC on decode acknowledge (unless stalled).
//                Optional feature macro: FETCH_MISALIGN_TRAP_EN enables the
//                misaligned-target trap redirect and MisalignTrap pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_pc_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        NextPCSrc,
    input  logic [31:0] ALURes,
    input  logic        Stall,
    input  logic        InstrAck,
    input  logic        IMemReady,
    input  logic        IMemValid,
    input  logic [31:0] IMemRData,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        MisalignTrap
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_instr_valid;
    logic         r_imem_req;

    logic         w_accept;
    logic [31:0]  w_next_pc;
    logic         w_misalign;

    // Decode takes the held instruction only when no hazard hold is active
    assign w_accept = (r_state == S_HOLD) & InstrAck & ~Stall;

    pc_next_sel #(
        .TRAP_VEC      (TRAP_VEC)
    ) u_pc_next_sel (
        .i_pc          (r_pc),
        .i_alu_res     (ALURes),
        .i_next_pc_src (NextPCSrc),
        .o_next_pc     (w_next_pc),
        .o_misalign    (w_misalign)
    );

    // Fetch FSM with registered request, instruction and PC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RESET;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
                S_REQ: begin
                    // A response in the same cycle as ready is not ours yet
                    if (IMemReady) begin
                        r_state    <= S_WAIT;
                        r_imem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (IMemValid) begin
                        r_instr       <= IMemRData;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                default: begin
                    r_state    <= S_RESET;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign_trap;

    // One-cycle trap pulse following an accepted misaligned redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign_trap <= 1'b0;
        end else begin
            r_misalign_trap <= w_accept & w_misalign;
        end
    end

    assign MisalignTrap = r_misalign_trap;
`else
    logic w_unused_misalign;

    assign w_unused_misalign = w_misalign;
    assign MisalignTrap      = 1'b0;
`endif

    assign IMemReq    = r_imem_req;
    assign IMemAddr   = r_pc;
    assign Instr      = r_instr;
    assign InstrValid = r_instr_valid;
    assign PC         = r_pc;
    assign PCPlus4    = pc_plus4(r_pc);

endmodule : fetch_pc_unit
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fetch_pc_unit
//  Description : Randomized scoreboard bench for fetch_pc_unit. A driver
//                plays instruction memory and decode, keeps a reference PC
//                and pushes expected fetch addresses and instructions; a
//                monitor pops and compares when handshakes occur.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_pc_unit;

    localparam logic [31:0] c_rst_pc = 32'h0000_0000;
    localparam logic [31:0] c_trap   = 32'h0000_0100;
    localparam logic [31:0] c_nop    = 32'h0000_0013;
    localparam int          c_cycles = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        NextPCSrc = 1'b0;
    logic [31:0] ALURes = '0;
    logic        Stall = 1'b0;
    logic        InstrAck = 1'b0;
    logic        IMemReady = 1'b0;
    logic        IMemValid = 1'b0;
    logic [31:0] IMemRData = '0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        MisalignTrap;

    always #5 clk = ~clk;

    fetch_pc_unit #(
        .RESET_PC     (c_rst_pc),
        .TRAP_VEC     (c_trap)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .NextPCSrc    (NextPCSrc),
        .ALURes       (ALURes),
        .Stall        (Stall),
        .InstrAck     (InstrAck),
        .IMemReady    (IMemReady),
        .IMemValid    (IMemValid),
        .IMemRData    (IMemRData),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .Instr        (Instr),
        .InstrValid   (InstrValid),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .MisalignTrap (MisalignTrap)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct packed {
        logic        src;
        logic [31:0] alu;
    } dir_t;

    logic [31:0] exp_addr_q[$];
    exp_t        exp_instr_q[$];
    dir_t        force_q[$];

    int checks  = 0;
    int errors  = 0;
    int retired = 0;

    // Reference next-PC rule
    function automatic logic [31:0] ref_next(input logic [31:0] pc,
                                             input logic src,
                                             input logic [31:0] alu);
        if (!src) return pc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (alu[1]) return c_trap;
        return alu & 32'hFFFF_FFFE;
`else
        return alu & 32'hFFFF_FFFC;
`endif
    endfunction

    function automatic logic ref_trap(input logic src, input logic [31:0] alu);
`ifdef FETCH_MISALIGN_TRAP_EN
        return src & alu[1];
`else
        return 1'b0 & src & alu[1];
`endif
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic load_force();
        force_q.delete();
        force_q.push_back('{src: 1'b0, alu: 32'h0});
        force_q.push_back('{src: 1'b0, alu: 32'h0});
        force_q.push_back('{src: 1'b1, alu: 32'h0000_0101});
        force_q.push_back('{src: 1'b1, alu: 32'hFFFF_FFFC});
        force_q.push_back('{src: 1'b0, alu: 32'h0});
        force_q.push_back('{src: 1'b1, alu: 32'h0000_0202});
        force_q.push_back('{src: 1'b0, alu: 32'h0});
        force_q.push_back('{src: 1'b1, alu: 32'h0000_0001});
    endtask

    function automatic logic [31:0] pick_alu();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return $urandom & 32'hFFFF_FFFC;
            2:       return 32'hFFFF_FFFC;
            default: return $urandom | 32'h2;
        endcase
    endfunction

    // Driver: memory model, decode model and reference PC
    initial begin
        logic [31:0] model_pc;
        bit          outstanding;
        int          delay;
        int          ready_block;
        int          stall_block;
        bit          did_mid_rst;
        dir_t        d;

        outstanding = 0;
        delay       = 0;
        ready_block = 0;
        stall_block = 0;
        did_mid_rst = 0;
        model_pc    = c_rst_pc;
        exp_addr_q.push_back(c_rst_pc);
        load_force();

        @(posedge clk); #1;
        @(posedge clk); #1;

        for (int cyc = 0; cyc < c_cycles; cyc++) begin
            if (!did_mid_rst && cyc > 600 && outstanding) begin
                // Reset while a response is in flight; memory drops it too
                rst         = 1'b1;
                IMemValid   = 1'b0;
                IMemReady   = 1'b1;
                InstrAck    = 1'b1;
                Stall       = 1'b0;
                outstanding = 0;
                did_mid_rst = 1;
                exp_addr_q.delete();
                exp_instr_q.delete();
                model_pc = c_rst_pc;
                exp_addr_q.push_back(c_rst_pc);
                load_force();
            end else begin
                rst = 1'b0;

                // Response channel
                if (outstanding && delay == 0) begin
                    IMemValid = 1'b1;
                    IMemRData = $urandom;
                    exp_instr_q.push_back('{pc: model_pc, instr: IMemRData});
                    outstanding = 0;
                end else begin
                    if (outstanding) delay--;
                    IMemValid = !outstanding && ($urandom_range(0, 3) == 0);
                    IMemRData = {16'hBAD0, 16'($urandom)};
                end

                // Request channel, with occasional long not-ready bursts
                if (ready_block == 0 && $urandom_range(0, 19) == 0) ready_block = 5;
                if (ready_block > 0) begin
                    IMemReady = 1'b0;
                    ready_block--;
                end else begin
                    IMemReady = ($urandom_range(0, 2) != 0);
                end
                if (IMemReq && IMemReady) begin
                    outstanding = 1;
                    delay       = $urandom_range(0, 3);
                end

                // Decode side
                if (InstrValid && stall_block == 0 && $urandom_range(0, 15) == 0) stall_block = 4;
                if (stall_block > 0) begin
                    Stall    = 1'b1;
                    InstrAck = 1'b1;
                    stall_block--;
                end else begin
                    Stall    = ($urandom_range(0, 3) == 0);
                    InstrAck = ($urandom_range(0, 3) != 0);
                end
                NextPCSrc = 1'($urandom);
                ALURes    = pick_alu();
                if (InstrValid && InstrAck && !Stall) begin
                    if (force_q.size() > 0) begin
                        d = force_q.pop_front();
                        NextPCSrc = d.src;
                        ALURes    = d.alu;
                    end
                    model_pc = ref_next(model_pc, NextPCSrc, ALURes);
                    exp_addr_q.push_back(model_pc);
                end
            end
            @(posedge clk); #1;
        end

        rst       = 1'b0;
        IMemReady = 1'b0;
        IMemValid = 1'b0;
        InstrAck  = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (retired < 100 || !did_mid_rst) begin
            errors++;
            $display("FAIL progress retired=%0d required>=100 mid_reset=%0d", retired, did_mid_rst);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: compares DUT handshakes against the scoreboard queues
    initial begin
        bit   prev_rst;
        bit   exp_trap;
        bit   next_trap;
        exp_t e;

        prev_rst = 0;
        exp_trap = 0;
        forever begin
            @(negedge clk);
            next_trap = 0;
            if (prev_rst) begin
                chk32("reset_pc", PC, c_rst_pc);
                chk32("reset_instr", Instr, c_nop);
                chk32("reset_valid", {31'b0, InstrValid}, 32'd0);
                chk32("reset_req", {31'b0, IMemReq}, 32'd0);
                chk32("reset_trap", {31'b0, MisalignTrap}, 32'd0);
            end else begin
                chk32("trap_pulse", {31'b0, MisalignTrap}, {31'b0, exp_trap});
            end
            if (!rst) begin
                if (IMemReq && IMemReady) begin
                    checks++;
                    if (exp_addr_q.size() == 0) begin
                        errors++;
                        $display("FAIL fetch_addr actual=%h expected=<none>", IMemAddr);
                    end else begin
                        checks--;
                        chk32("fetch_addr", IMemAddr, exp_addr_q.pop_front());
                    end
                end
                if (InstrValid) begin
                    chk32("no_req_in_hold", {31'b0, IMemReq}, 32'd0);
                end
                if (InstrValid && InstrAck && !Stall) begin
                    checks++;
                    if (exp_instr_q.size() == 0) begin
                        errors++;
                        $display("FAIL instr actual=%h expected=<none>", Instr);
                    end else begin
                        checks--;
                        e = exp_instr_q.pop_front();
                        chk32("instr", Instr, e.instr);
                        chk32("pc", PC, e.pc);
                        chk32("pc_plus4", PCPlus4, e.pc + 32'd4);
                        retired++;
                        next_trap = ref_trap(NextPCSrc, ALURes);
                    end
                end
            end
            exp_trap = next_trap;
            prev_rst = rst;
        end
    end

endmodule : tb_fetch_pc_unit
`default_nettype wire
